mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It runs a request/ack handshake toward memory with one outstanding transaction. It returns read data and a one-cycle ready pulse to each requester. It also generates the structural-hazard stall signals that freeze the pipeline alongside the load-use hazard logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready or if_kill
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_kill  in  1  branch flush: discard the pending/in-flight fetch
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle fetch-complete pulse
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_ready=1
- dm_ready  out  1  one-cycle data-complete pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- stall_if  out  1  if_req & ~if_ready: hold PC and IF/ID, bubble into ID/EX
- stall_mem  out  1  dm_req & ~dm_ready: freeze all pipeline registers

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE: sample the requests.
  - Only dm_req=1: go to DM_BUSY.
  - Only if_req=1 and if_kill=0: go to IF_BUSY.
  - Both pending: round-robin, granting the requester not served last. The last-grant register resets to "IF", so data wins the first tie.
  - Granting loads mem_addr/mem_we/mem_wdata (mem_we=0 for fetch) and sets mem_req=1.
- IF_BUSY / DM_BUSY: hold mem_req and the mem_* outputs stable until mem_ack=1.
  - On ack, clear mem_req and go to RESP.
  - On a read, capture mem_rdata into if_rdata or dm_rdata.
  - Update last-grant.
- RESP: assert the granted ready for exactly this cycle, ignore all requests, then return to IDLE.
- if_kill=1 during IF_BUSY: set a kill flag. The memory transaction still completes, since mem_req is never withdrawn. On ack the FSM goes straight to IDLE: no if_ready pulse and no if_rdata update.
- if_kill=1 in IDLE blocks a fetch grant that cycle.
- if_kill=1 in RESP after a fetch suppresses if_ready.
- Stores do not update dm_rdata; it keeps its previous value.
- mem_ack outside the BUSY states is ignored.
- stall_if and stall_mem are combinational from the inputs and the registered ready pulses. The ready pulses are registered, so no combinational path runs from mem_* to the stalls.

## Timing
- Reset (async, immediate): state=IDLE, last-grant=IF, kill flag=0.
  - All mem_* outputs are 0.
  - if_ready=dm_ready=0 and if_rdata=dm_rdata=0.
  - The stall outputs follow their equations, e.g. if_req=1 during reset gives stall_if=1.
- Reset mid-transaction drops mem_req at once. The memory must tolerate the abandoned request; a late ack is ignored.
- Cycle sequence:
  - Request seen at edge N.
  - mem_req=1 from N (registered).
  - mem_ack earliest in cycle N, sampled at edge N+1.
  - ready=1 in cycle N+1.
  - IDLE at N+2.
- Minimum service time is 3 cycles per transaction. A back-to-back request is granted no earlier than edge N+2.
- The requester deasserts req on the edge ending its ready cycle. RESP guarantees that no duplicate grant occurs.
- mem_ack held high in the grant cycle completes the transaction in one memory cycle.

## Test plan
- **Single fetch:** if_req=1, addr=0x40; mem_ack 2 cycles after mem_req with rdata=0x8C220004.
  - mem_addr=0x40, mem_we=0.
  - if_ready pulses once with if_rdata=0x8C220004.
  - stall_if=1 until the ready cycle.
- **Store:** dm_req=1, dm_we=1, addr=0x100, wdata=0xDEADBEEF.
  - mem_we=1 with matching addr/wdata.
  - dm_ready pulses once.
  - dm_rdata is unchanged.
- **Contention:** if_req and dm_req high together from reset.
  - DM is served first, then IF.
  - Repeat with both held: grants alternate DM, IF, DM.
- **Kill:** if_kill pulsed during IF_BUSY, before ack with rdata=0x12345678.
  - No if_ready pulse.
  - if_rdata unchanged.
  - FSM returns to IDLE and a new fetch is granted next.
- **Reset mid-operation:** rst_n low while DM_BUSY.
  - mem_req=0 immediately and all outputs are at reset values.
  - An ack arriving after reset release causes no ready pulse.
- **Zero-wait memory:** mem_ack tied high.
  - Each transaction takes exactly 3 cycles.
  - No duplicate grant occurs while req is held through the ready cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM-stage request ports, the shared memory bus and the stall outputs.
// The slave modport is the arbiter; the master modport is the pipeline and memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_kill, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and load/store,
// with one outstanding transaction, round-robin tie-break and structural-hazard stalls.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

  state_t            state;
  logic              last_grant_if;
  logic              kill_flag;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic              if_ready_w;
  logic              if_eligible;
  logic              grant_dm;
  logic              grant_if;

  // A killed fetch is never eligible; on a tie the side not served last wins.
  always_comb begin
    if_eligible = bus.if_req & ~bus.if_kill;
    grant_dm    = bus.dm_req & (~if_eligible | last_grant_if);
    grant_if    = if_eligible & ~grant_dm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_if <= 1'b1;
      kill_flag     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_ready_q    <= 1'b0;
      dm_ready_q    <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state       <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
          end else if (grant_if) begin
            state       <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end
        end
        IF_BUSY: begin
          if (bus.if_kill) begin
            kill_flag <= 1'b1;
          end
          // A flushed fetch still finishes on the bus but is dropped without a response.
          if (bus.mem_ack) begin
            mem_req_q     <= 1'b0;
            last_grant_if <= 1'b1;
            kill_flag     <= 1'b0;
            if (kill_flag || bus.if_kill) begin
              state <= IDLE;
            end else begin
              state      <= RESP;
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        DM_BUSY: begin
          if (bus.mem_ack) begin
            mem_req_q     <= 1'b0;
            last_grant_if <= 1'b0;
            state         <= RESP;
            dm_ready_q    <= 1'b1;
            if (!mem_we_q) begin
              dm_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Flush arriving during the response cycle still suppresses the fetch pulse.
  assign if_ready_w    = if_ready_q & ~bus.if_kill;

  assign bus.if_ready  = if_ready_w;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_w;
  assign bus.stall_mem = bus.dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers the bus, expected grants
// and responses are queued when requests are driven and compared when the DUT produces them.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_grants[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  logic [31:0] mem[logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          if_pulses = 0;
  int          dm_pulses = 0;
  bit          model_en = 1'b1;
  bit          ack_tied = 1'b0;
  int          ack_delay = 1;
  logic [31:0] last_dm_load = '0;
  logic [31:0] last_fetch = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: acks ack_delay cycles after seeing mem_req, or every cycle when tied high.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        wait_cnt = 0;
      end else if (!rst_n) begin
        bus.mem_ack = ack_tied;
        wait_cnt = 0;
      end else if (bus.mem_req && (ack_tied || wait_cnt >= ack_delay)) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_we ? 32'h0 : mem_rd(bus.mem_addr);
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        wait_cnt = 0;
      end else begin
        bus.mem_ack = ack_tied;
        wait_cnt = bus.mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Monitor: new grants and ready pulses are popped from the scoreboard.
  initial begin
    logic   prev_req;
    grant_t g;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_req && !prev_req) begin
          if (exp_grants.size() == 0) begin
            check("unexpected_grant", {32'h0, bus.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            g = exp_grants.pop_front();
            check("grant_we", bus.mem_we, g.we);
            check("grant_addr", bus.mem_addr, g.addr);
            if (g.we) check("grant_wdata", bus.mem_wdata, g.wdata);
          end
        end
        if (bus.if_ready) begin
          if_pulses++;
          if (exp_if.size() == 0) check("unexpected_if_ready", 1, 0);
          else check("if_rdata", bus.if_rdata, exp_if.pop_front());
        end
        if (bus.dm_ready) begin
          dm_pulses++;
          if (exp_dm.size() == 0) check("unexpected_dm_ready", 1, 0);
          else check("dm_rdata", bus.dm_rdata, exp_dm.pop_front());
        end
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic push_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    grant_t g;
    g.we = we;
    g.addr = addr;
    g.wdata = wdata;
    exp_grants.push_back(g);
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    exp_if.push_back(mem_rd(addr));
    last_fetch = mem_rd(addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      lat++;
      if (bus.if_ready) begin
        got = 1'b1;
        break;
      end
      check("stall_if_wait", bus.stall_if, 1);
    end
    check("if_ready_seen", got, 1);
    if (got) check("stall_if_ready", bus.stall_if, 0);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    if (!we) last_dm_load = mem_rd(addr);
    exp_dm.push_back(last_dm_load);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      lat++;
      if (bus.dm_ready) begin
        got = 1'b1;
        break;
      end
      check("stall_mem_wait", bus.stall_mem, 1);
    end
    check("dm_ready_seen", got, 1);
    if (got) check("stall_mem_ready", bus.stall_mem, 0);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_dm_ready", bus.dm_ready, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
  endtask

  initial begin
    int lat;
    int lat2;
    int pulses0;
    bit seen;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem[32'h40]  = 32'h8C22_0004;
    mem[32'h44]  = 32'h0042_2020;
    mem[32'h80]  = 32'h1234_5678;
    mem[32'h200] = 32'h1111_2222;
    mem[32'h204] = 32'h3333_4444;

    // Reset state, stall equation live during reset.
    bus.if_req = 1'b1;
    #12;
    check_reset_outputs();
    check("rst_stall_if", bus.stall_if, 1);
    check("rst_stall_mem", bus.stall_mem, 0);
    bus.if_req = 1'b0;
    #1;
    check("rst_stall_if_low", bus.stall_if, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from reset: DM first, then IF.
    ack_delay = 1;
    push_grant(1'b0, 32'h200, 32'h0);
    push_grant(1'b0, 32'h40, 32'h0);
    fork
      do_data(1'b0, 32'h200, 32'h0, lat);
      do_fetch(32'h40, lat2);
    join
    // Both held across three grants: DM, IF, DM.
    push_grant(1'b0, 32'h204, 32'h0);
    push_grant(1'b0, 32'h44, 32'h0);
    push_grant(1'b0, 32'h200, 32'h0);
    fork
      begin
        do_data(1'b0, 32'h204, 32'h0, lat);
        do_data(1'b0, 32'h200, 32'h0, lat);
      end
      do_fetch(32'h44, lat2);
    join
    repeat (3) @(posedge clk);
    #1;

    // Single fetch with a two-cycle memory.
    ack_delay = 2;
    push_grant(1'b0, 32'h40, 32'h0);
    do_fetch(32'h40, lat);
    check("fetch_latency", lat, 5);

    // Store: dm_rdata keeps the last load value.
    push_grant(1'b1, 32'h100, 32'hDEAD_BEEF);
    do_data(1'b1, 32'h100, 32'hDEAD_BEEF, lat);
    check("store_mem", mem_rd(32'h100), 32'hDEAD_BEEF);
    push_grant(1'b0, 32'h100, 32'h0);
    do_data(1'b0, 32'h100, 32'h0, lat);

    // Kill during IF_BUSY.
    pulses0 = if_pulses;
    push_grant(1'b0, 32'h80, 32'h0);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h80;
    seen = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("kill_grant_seen", seen, 1);
    @(posedge clk); #1;
    bus.if_kill = 1'b1;
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    bus.if_kill = 1'b0;
    repeat (3) @(negedge clk);
    check("kill_if_rdata", bus.if_rdata, 32'h8C22_0004);
    check("kill_no_pulse", if_pulses, pulses0);
    check("kill_idle_req", bus.mem_req, 0);
    push_grant(1'b0, 32'h44, 32'h0);
    do_fetch(32'h44, lat);
    check("kill_pulse_count", if_pulses, pulses0 + 1);

    // Zero-wait memory: three cycles each, no duplicate grants.
    ack_tied = 1'b1;
    @(posedge clk); #1;
    push_grant(1'b0, 32'h40, 32'h0);
    do_fetch(32'h40, lat);
    check("zw_fetch_lat", lat, 3);
    push_grant(1'b1, 32'h300, 32'hCAFE_F00D);
    do_data(1'b1, 32'h300, 32'hCAFE_F00D, lat);
    check("zw_store_lat", lat, 3);
    push_grant(1'b0, 32'h300, 32'h0);
    do_data(1'b0, 32'h300, 32'h0, lat);
    check("zw_load_lat", lat, 3);
    repeat (4) @(negedge clk);
    check("zw_no_extra_grant", exp_grants.size(), 0);
    ack_tied = 1'b0;
    @(posedge clk); #1;

    // Reset during DM_BUSY, then a late ack.
    model_en = 1'b0;
    bus.mem_ack = 1'b0;
    push_grant(1'b0, 32'h204, 32'h0);
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_addr = 32'h204;
    seen = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstmid_grant_seen", seen, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    check("rstmid_stall_mem", bus.stall_mem, 1);
    bus.dm_req = 1'b0;
    pulses0 = dm_pulses;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_dm_load = '0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_no_ready", dm_pulses, pulses0);
    check("late_ack_mem_req", bus.mem_req, 0);
    check("late_ack_dm_rdata", bus.dm_rdata, 0);
    model_en = 1'b1;
    ack_delay = 1;

    // Normal service resumes after reset.
    push_grant(1'b0, 32'h200, 32'h0);
    do_data(1'b0, 32'h200, 32'h0, lat);
    repeat (3) @(negedge clk);

    check("left_grants", exp_grants.size(), 0);
    check("left_if", exp_if.size(), 0);
    check("left_dm", exp_dm.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
